// File: rtl/matvec3_result_packer.sv
// matvec3_result_packer: groups three saturated elements into a vector with argmax and clip flag, buffered in a FIFO
module matvec3_result_packer #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*OUT_W-1:0]      out_data,
  output logic [1:0]              out_argmax,
  output logic                    out_sat
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [IN_W-1:0] SMAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SMIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic [1:0]               r_idx;
  logic signed [OUT_W-1:0]  r_a0, r_a1;
  logic                     r_c0, r_c1;
  logic [3*OUT_W-1:0]       r_data [DEPTH];
  logic [1:0]               r_arg  [DEPTH];
  logic                     r_sat  [DEPTH];
  logic [PW-1:0]            r_wp, r_rp;
  logic [CW-1:0]            r_cnt;
  logic                     w_hi, w_lo, w_clip, w_acc, w_push, w_pop, w_vsat;
  logic signed [OUT_W-1:0]  w_s;
  logic [1:0]               w_am;
  logic [3*OUT_W-1:0]       w_vec;
  // saturation of the incoming element, argmax of the vector being closed, handshakes and head view
  always_comb begin
    w_hi       = in_data > SMAX;
    w_lo       = in_data < SMIN;
    w_clip     = w_hi | w_lo;
    w_s        = w_hi ? SMAX[OUT_W-1:0] : w_lo ? SMIN[OUT_W-1:0] : in_data[OUT_W-1:0];
    w_am       = (r_a1 > r_a0) ? ((w_s > r_a1) ? 2'd2 : 2'd1) : ((w_s > r_a0) ? 2'd2 : 2'd0);
    w_vec      = {w_s, r_a1, r_a0};
    w_vsat     = w_clip | r_c0 | r_c1;
    in_ready   = (r_idx != 2'd2) || (r_cnt < CW'(DEPTH));
    out_valid  = r_cnt != '0;
    w_acc      = in_valid && in_ready;
    w_push     = w_acc && (r_idx == 2'd2);
    w_pop      = out_valid && out_ready;
    out_data   = r_data[r_rp];
    out_argmax = r_arg[r_rp];
    out_sat    = r_sat[r_rp];
  end
  // element position counter and assembly registers for elements 0 and 1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
      r_a0  <= '0;
      r_a1  <= '0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
    end else if (w_acc) begin
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      if (r_idx == 2'd0) begin
        r_a0 <= w_s;
        r_c0 <= w_clip;
      end
      if (r_idx == 2'd1) begin
        r_a1 <= w_s;
        r_c1 <= w_clip;
      end
    end
  end
  // in-order vector FIFO; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_arg[i]  <= '0;
        r_sat[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wp] <= w_vec;
        r_arg[r_wp]  <= w_am;
        r_sat[r_wp]  <= w_vsat;
        r_wp         <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_matvec3_result_packer.sv
// tb_matvec3_result_packer: randomized and directed checks against a queue-based vector model
module tb_matvec3_result_packer;
  localparam int IN_W = 28, OUT_W = 16, DEPTH = 2;
  typedef struct { logic [47:0] d; logic [1:0] a; logic s; } vec_t;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic signed [IN_W-1:0] in_data = '0;
  logic in_ready, out_valid, out_sat;
  logic [47:0] out_data;
  logic [1:0] out_argmax;
  int errors = 0, checks = 0, m_cnt = 0;
  longint part[$];
  vec_t exp_q[$], got_q[$];

  matvec3_result_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_argmax(out_argmax), .out_sat(out_sat));

  always #5 clk = ~clk;

  function automatic vec_t ref_vec(longint x0, longint x1, longint x2);
    longint x[3], s[3];
    vec_t v;
    int am;
    x[0] = x0; x[1] = x1; x[2] = x2;
    v.s = 0;
    for (int i = 0; i < 3; i++) begin
      s[i] = x[i] > 32767 ? 32767 : x[i] < -32768 ? -32768 : x[i];
      if (s[i] != x[i]) v.s = 1;
    end
    am = 0;
    for (int i = 1; i < 3; i++) if (s[i] > s[am]) am = i;
    v.a = 2'(am);
    v.d = {16'(s[2]), 16'(s[1]), 16'(s[0])};
    return v;
  endfunction

  // advance one clock, updating the model with the handshakes that happen at this edge
  task automatic tick();
    bit rdy, acc, pop;
    rdy = part.size() != 2 || m_cnt < DEPTH;
    acc = in_valid && rdy;
    pop = m_cnt > 0 && out_ready;
    if (pop) begin
      got_q.push_back('{out_data, out_argmax, out_sat});
      m_cnt--;
    end
    if (acc) begin
      part.push_back(longint'(in_data));
      if (part.size() == 3) begin
        exp_q.push_back(ref_vec(part[0], part[1], part[2]));
        part.delete();
        m_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    reset = 0;
    part.delete(); exp_q.delete(); got_q.delete(); m_cnt = 0;
  endtask

  task automatic drain();
    out_ready = 1; in_valid = 0;
    for (int k = 0; k < 20 && m_cnt > 0; k++) tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_data !== 48'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    if (out_argmax !== 2'd0) begin errors++; $display("FAIL reset_argmax: got %0d want 0", out_argmax); end
    if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", out_sat); end
  endtask

  task automatic test_basic();
    out_ready = 1; in_valid = 1;
    in_data = 100; tick();
    in_data = -5; tick();
    in_data = 300;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    tick();
    in_valid = 0;
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", out_valid); end
    if (out_data !== {16'd300, 16'hfffb, 16'd100}) begin errors++; $display("FAIL basic_data: got %h want %h", out_data, {16'd300, 16'hfffb, 16'd100}); end
    if (out_argmax !== 2'd2) begin errors++; $display("FAIL basic_argmax: got %0d want 2", out_argmax); end
    if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", out_sat); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 0; in_valid = 1;
    in_data = 40000; tick();
    in_data = -40000; tick();
    in_data = 32767; tick();
    in_valid = 0;
    checks += 3;
    if (out_data !== {16'h7fff, 16'h8000, 16'h7fff}) begin errors++; $display("FAIL sat_data: got %h want %h", out_data, {16'h7fff, 16'h8000, 16'h7fff}); end
    if (out_argmax !== 2'd0) begin errors++; $display("FAIL sat_argmax: got %0d want 0", out_argmax); end
    if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", out_sat); end
  endtask

  task automatic test_stall();
    logic [47:0] d0;
    logic [1:0] a0;
    logic s0;
    d0 = out_data; a0 = out_argmax; s0 = out_sat;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_argmax !== a0 || out_sat !== s0) begin
        errors++;
        $display("FAIL stall_hold: got v=%b %h/%0d/%b want v=1 %h/%0d/%b", out_valid, out_data, out_argmax, out_sat, d0, a0, s0);
      end
    end
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL stall_pop: got %0d vectors want 2 matching model", got_q.size()); end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = 28'($urandom);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL full_accept%0d: got %b want 1", k, in_ready); end
      tick();
    end
    in_data = 28'($urandom_range(0, 70000)) - 28'sd35000;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL full_block%0d: got %b want 0", k, in_ready); end
      tick();
    end
    out_ready = 1; tick(); out_ready = 0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", in_ready); end
    tick();
    drain();
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL full_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_order%0d: got %h want %h", i, got_q[i].d, exp_q[i].d); end
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin in_data = 28'($urandom_range(0, 60000)) - 28'sd30000; tick(); end
    in_data = 28'sd1234; out_ready = 1;
    tick();
    out_ready = 0; in_valid = 0;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_valid: got %b want 1", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b want 1", in_ready); end
    if (out_data !== exp_q[1].d) begin errors++; $display("FAIL pp_head: got %h want %h", out_data, exp_q[1].d); end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_count1: got %b want 1", out_valid); end
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL pp_order: got %0d vectors want 2 matching model", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1; in_valid = 1;
    in_data = 28'sd7777; tick();
    in_data = 28'sd8888; tick();
    in_data = 28'sd9999; reset = 1;
    @(posedge clk); #1;
    reset = 0; in_valid = 0;
    part.delete(); exp_q.delete(); got_q.delete(); m_cnt = 0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    in_valid = 1;
    in_data = -28'sd3; tick();
    in_data = 28'sd50; tick();
    in_data = 28'sd50; tick();
    in_valid = 0;
    checks += 2;
    if (out_data !== {16'd50, 16'd50, 16'hfffd} || out_argmax !== 2'd1) begin errors++; $display("FAIL rmid_fresh: got %h/%0d want %h/1", out_data, out_argmax, {16'd50, 16'd50, 16'hfffd}); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_out: got %b want 1", out_valid); end
    drain();
  endtask

  task automatic test_random();
    int v;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      v = ($urandom % 3 == 0) ? int'($urandom) : int'($urandom_range(0, 80000)) - 40000;
      in_data = 28'(v);
      checks += 2;
      if (in_ready !== (part.size() != 2 || m_cnt < DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %b", k, in_ready); end
      if (out_valid !== (m_cnt > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", k, out_valid, m_cnt > 0); end
      if (m_cnt > 0) begin
        checks++;
        if (out_data !== exp_q[got_q.size()].d || out_argmax !== exp_q[got_q.size()].a || out_sat !== exp_q[got_q.size()].s)
          begin errors++; $display("FAIL rnd_head@%0d: got %h/%0d/%b want %h/%0d/%b", k, out_data, out_argmax, out_sat,
            exp_q[got_q.size()].d, exp_q[got_q.size()].a, exp_q[got_q.size()].s); end
      end
      tick();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < 20) begin errors++; $display("FAIL rnd_total: got %0d want %0d", got_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
